alu_operand_stage: RTL and testbench

Parametrised, registered successor to the combinational ALU operand-B mux. Selects ALU operand A and operand B for the EX stage of the pipelined MIPS datapath. Operand B can be a register, a sign-extended immediate, a zero-extended immediate or a shift amount. Applies EX/MEM and MEM/WB forwarding to both operands and presents results through an ID/EX-side pipeline register with valid, stall and flush control.

---
 rtl/alu_operand_stage.sv | 98 +++++++++
 tb/tb_alu_operand_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// EX-stage operand selection for the pipelined MIPS datapath: forwarding muxes,
// immediate/shamt extension, and one registered stage with flush/stall control.
module alu_operand_stage #(
    parameter int WIDTH       = 32,
    parameter int IMM_WIDTH   = 16,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [1:0]             ALUsrc,
    input  logic [1:0]             fwdA,
    input  logic [1:0]             fwdB,
    input  logic [WIDTH-1:0]       read_d1,
    input  logic [WIDTH-1:0]       read_d2,
    input  logic [IMM_WIDTH-1:0]   imm,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [WIDTH-1:0]       exmem_result,
    input  logic [WIDTH-1:0]       memwb_result,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       ALUin1,
    output logic [WIDTH-1:0]       ALUin2,
    output logic [WIDTH-1:0]       store_data
);

    logic [WIDTH-1:0] w_fwdA_val_p0;
    logic [WIDTH-1:0] w_fwdB_val_p0;
    logic [WIDTH-1:0] w_sext_p0;
    logic [WIDTH-1:0] w_zext_p0;
    logic [WIDTH-1:0] w_shx_p0;
    logic [WIDTH-1:0] w_opB_p0;

    logic             r_vld_p1;
    logic [WIDTH-1:0] r_alu_in1_p1;
    logic [WIDTH-1:0] r_alu_in2_p1;
    logic [WIDTH-1:0] r_store_data_p1;

    // Stage p0: combinational operand selection; code 3 aliases the register value.
    always_comb begin
        w_fwdA_val_p0 = read_d1;
        case (fwdA)
            2'd1:    w_fwdA_val_p0 = exmem_result;
            2'd2:    w_fwdA_val_p0 = memwb_result;
            default: w_fwdA_val_p0 = read_d1;
        endcase
    end

    always_comb begin
        w_fwdB_val_p0 = read_d2;
        case (fwdB)
            2'd1:    w_fwdB_val_p0 = exmem_result;
            2'd2:    w_fwdB_val_p0 = memwb_result;
            default: w_fwdB_val_p0 = read_d2;
        endcase
    end

    assign w_sext_p0 = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    assign w_zext_p0 = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
    assign w_shx_p0  = {{(WIDTH-SHAMT_WIDTH){1'b0}}, shamt};

    always_comb begin
        w_opB_p0 = w_fwdB_val_p0;
        case (ALUsrc)
            2'd1:    w_opB_p0 = w_sext_p0;
            2'd2:    w_opB_p0 = w_zext_p0;
            2'd3:    w_opB_p0 = w_shx_p0;
            default: w_opB_p0 = w_fwdB_val_p0;
        endcase
    end

    // Stage p1: output register, flush beats stall beats load; data loads even for bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p1        <= 1'b0;
            r_alu_in1_p1    <= '0;
            r_alu_in2_p1    <= '0;
            r_store_data_p1 <= '0;
        end else if (flush) begin
            r_vld_p1        <= 1'b0;
            r_alu_in1_p1    <= '0;
            r_alu_in2_p1    <= '0;
            r_store_data_p1 <= '0;
        end else if (!stall) begin
            r_vld_p1        <= in_valid;
            r_alu_in1_p1    <= w_fwdA_val_p0;
            r_alu_in2_p1    <= w_opB_p0;
            r_store_data_p1 <= w_fwdB_val_p0;
        end
    end

    assign out_valid  = r_vld_p1;
    assign ALUin1     = r_alu_in1_p1;
    assign ALUin2     = r_alu_in2_p1;
    assign store_data = r_store_data_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a 32-bit and a 16-bit instance share
// one stimulus stream and are compared every cycle against an arithmetic model.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [1:0]  ALUsrc = '0, fwdA = '0, fwdB = '0;
    logic [31:0] rd1 = '0, rd2 = '0, ex = '0, mw = '0;
    logic [15:0] imm = '0;
    logic [4:0]  shamt = '0;

    logic        w_v,  n_v;
    logic [31:0] w_a1, w_a2, w_sd;
    logic [15:0] n_a1, n_a2, n_sd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [31:0] a1, a2, sd;
        logic        nv;
        logic [31:0] n1, n2, nsd;
    } exp_t;

    exp_t q[$];
    exp_t m;

    always #5 clock = ~clock;

    alu_operand_stage #(.WIDTH(32), .IMM_WIDTH(16), .SHAMT_WIDTH(5)) dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALUsrc(ALUsrc), .fwdA(fwdA), .fwdB(fwdB), .read_d1(rd1), .read_d2(rd2),
        .imm(imm), .shamt(shamt), .exmem_result(ex), .memwb_result(mw),
        .out_valid(w_v), .ALUin1(w_a1), .ALUin2(w_a2), .store_data(w_sd));

    alu_operand_stage #(.WIDTH(16), .IMM_WIDTH(8), .SHAMT_WIDTH(4)) dut_n (
        .clock(clock), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .ALUsrc(ALUsrc), .fwdA(fwdA), .fwdB(fwdB), .read_d1(rd1[15:0]), .read_d2(rd2[15:0]),
        .imm(imm[7:0]), .shamt(shamt[3:0]), .exmem_result(ex[15:0]), .memwb_result(mw[15:0]),
        .out_valid(n_v), .ALUin1(n_a1), .ALUin2(n_a2), .store_data(n_sd));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] r, input int w);
        logic [31:0] v;
        v = (f == 2'd1) ? ex : (f == 2'd2) ? mw : r;
        return v & mask(w);
    endfunction

    // Operand B for a stage of width w with an iw-bit immediate and sw-bit shamt.
    function automatic logic [31:0] opb(input int w, input int iw, input int sw);
        logic [31:0] iv;
        iv = imm & mask(iw);
        case (ALUsrc)
            2'd1: begin
                if ((iv >> (iw - 1)) & 32'd1) iv = iv | ~mask(iw);
                return iv & mask(w);
            end
            2'd2: return iv;
            2'd3: return shamt & mask(sw);
            default: return pick(fwdB, rd2, w);
        endcase
    endfunction

    function automatic exp_t next_state(input exp_t cur);
        exp_t nx;
        nx = cur;
        if (flush) begin
            nx = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0};
        end else if (!stall) begin
            nx.v   = in_valid;          nx.nv  = in_valid;
            nx.a1  = pick(fwdA, rd1, 32); nx.n1  = pick(fwdA, rd1, 16);
            nx.a2  = opb(32, 16, 5);    nx.n2  = opb(16, 8, 4);
            nx.sd  = pick(fwdB, rd2, 32); nx.nsd = pick(fwdB, rd2, 16);
        end
        return nx;
    endfunction

    // One cycle: inputs are already set (after a negedge); predict, push, cross the edge.
    task automatic step();
        m = next_state(m);
        q.push_back(m);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [1:0] src,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [15:0] im, input logic [4:0] sh);
        in_valid = v; stall = s; flush = f; ALUsrc = src; fwdA = fa; fwdB = fb;
        rd1 = d1; rd2 = d2; imm = im; shamt = sh;
        step();
    endtask

    task automatic randomize_inputs();
        in_valid = 1'($urandom);
        stall    = ($urandom % 4) == 0;
        flush    = ($urandom % 8) == 0;
        ALUsrc   = 2'($urandom); fwdA = 2'($urandom); fwdB = 2'($urandom);
        rd1 = $urandom; rd2 = $urandom; ex = $urandom; mw = $urandom;
        imm = 16'($urandom); shamt = 5'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wv"},  {31'd0, w_v}, 32'd0);
        chk({tag, "_wa1"}, w_a1, 32'd0);
        chk({tag, "_wa2"}, w_a2, 32'd0);
        chk({tag, "_wsd"}, w_sd, 32'd0);
        chk({tag, "_nv"},  {31'd0, n_v}, 32'd0);
        chk({tag, "_na2"}, {16'd0, n_a2}, 32'd0);
    endtask

    // Reset asserted between edges must clear outputs before any edge occurs.
    task automatic do_reset(input bit across_edge);
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        m = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0};
        if (across_edge) begin
            randomize_inputs();
            @(posedge clock);
            @(negedge clock);
            check_zero("rst_hold");
        end
        reset = 1'b0;
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (!reset && q.size() > 0) begin
            e = q.pop_front();
            chk("out_valid",  {31'd0, w_v}, {31'd0, e.v});
            chk("ALUin1",     w_a1, e.a1);
            chk("ALUin2",     w_a2, e.a2);
            chk("store_data", w_sd, e.sd);
            chk("n_out_valid",  {31'd0, n_v}, {31'd0, e.nv});
            chk("n_ALUin1",     {16'd0, n_a1}, e.n1);
            chk("n_ALUin2",     {16'd0, n_a2}, e.n2);
            chk("n_store_data", {16'd0, n_sd}, e.nsd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        m = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0};
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_zero("rst_state");

        ex = 32'hAA; mw = 32'hBB;
        drive(1, 0, 0, 2'd0, 2'd0, 2'd0, 32'd5, 32'd7, 16'h0, 5'd0);
        do_reset(1'b0);
        drive(1, 0, 0, 2'd0, 2'd0, 2'd0, 32'd5, 32'd7, 16'h0, 5'd0);

        drive(1, 0, 0, 2'd1, 2'd0, 2'd0, 32'd5, 32'd7, 16'h8001, 5'd31);
        drive(1, 0, 0, 2'd2, 2'd0, 2'd0, 32'd5, 32'd7, 16'h8001, 5'd31);
        drive(1, 0, 0, 2'd3, 2'd0, 2'd0, 32'd5, 32'd7, 16'h8001, 5'd31);

        drive(1, 0, 0, 2'd0, 2'd1, 2'd2, 32'd1, 32'd2, 16'h0, 5'd0);
        drive(1, 0, 0, 2'd0, 2'd3, 2'd1, 32'd1, 32'd2, 16'h0, 5'd0);
        drive(1, 0, 0, 2'd0, 2'd2, 2'd3, 32'd1, 32'd2, 16'h0, 5'd0);

        drive(1, 0, 0, 2'd0, 2'd0, 2'd0, 32'd5, 32'd7, 16'h0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1'b1; flush = 1'b0;
            step();
        end
        randomize_inputs();
        stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
        step();

        drive(1, 1, 1, 2'd0, 2'd0, 2'd0, 32'd9, 32'd9, 16'h0, 5'd0);
        drive(1, 0, 0, 2'd0, 2'd0, 2'd0, 32'd9, 32'd9, 16'h0, 5'd0);
        drive(1, 0, 1, 2'd0, 2'd0, 2'd0, 32'd9, 32'd9, 16'h0, 5'd0);

        drive(0, 0, 0, 2'd1, 2'd0, 2'd0, 32'd3, 32'd4, 16'h0080, 5'd0);

        drive(1, 0, 0, 2'd1, 2'd0, 2'd0, 32'd3, 32'd4, 16'h1234, 5'd3);
        stall = 1'b1;
        do_reset(1'b1);
        stall = 1'b0; flush = 1'b0;
        drive(1, 0, 0, 2'd0, 2'd0, 2'd0, 32'd11, 32'd12, 16'h0, 5'd0);

        for (int i = 0; i < 400; i++) begin
            if (($urandom % 64) == 0) begin
                do_reset(1'($urandom));
            end
            randomize_inputs();
            step();
        end

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
